// File: rtl/row_bus_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : row_bus_scheduler_pkg
// Purpose  : Shared widths, FSM encoding and display-block kinds for the row bus scheduler.
// Revision : 1.0
// ============================================================================
package row_bus_scheduler_pkg;

  localparam int CELL_W = 5;
  localparam int BLK_W  = 3;
  localparam int CELLS  = 13;
  localparam int BUS_W  = CELLS * BLK_W;
  localparam int ROW_W  = CELLS * CELL_W;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CONV  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  typedef enum logic [BLK_W-1:0] {
    BLK_EMPTY   = 3'd0,
    BLK_DIRT    = 3'd1,
    BLK_TUNNEL  = 3'd2,
    BLK_ANT     = 3'd3,
    BLK_FOOD    = 3'd4,
    BLK_QUEEN   = 3'd5,
    BLK_EGG     = 3'd6,
    BLK_INVALID = 3'd7
  } blk_t;

endpackage

`default_nettype wire

// File: rtl/row_bus_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : row_bus_scheduler_if
// Purpose  : Frame control, grid read port and row-bus handshake bundle.
// Revision : 1.0
// ============================================================================
interface row_bus_scheduler_if #(
  parameter int AW = 4
);

  logic                                    start;
  logic                                    busy;
  logic                                    done;
  logic                                    rd_en;
  logic [AW-1:0]                           row_addr;
  logic [row_bus_scheduler_pkg::ROW_W-1:0] rd_data;
  logic [row_bus_scheduler_pkg::BUS_W-1:0] bus_out;
  logic                                    bus_valid;
  logic                                    bus_ready;
  logic [AW-1:0]                           bus_row;

  modport master (
    input  start, rd_data, bus_ready,
    output busy, done, rd_en, row_addr, bus_out, bus_valid, bus_row
  );

  modport slave (
    output start, rd_data, bus_ready,
    input  busy, done, rd_en, row_addr, bus_out, bus_valid, bus_row
  );

endinterface

`default_nettype wire

// File: rtl/row_bus_scheduler_disp_to_block.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dispToBlock
// Purpose  : Maps a 5-bit display code to its 3-bit block kind (groups of four codes).
// Revision : 1.0
// ============================================================================
module dispToBlock
  import row_bus_scheduler_pkg::*;
(
  input  wire logic [CELL_W-1:0] i_code,
  output      logic [BLK_W-1:0]  o_blk
);

  blk_t w_kind;

  always_comb begin
    w_kind = BLK_INVALID;
    case (i_code) inside
      5'd0:           w_kind = BLK_EMPTY;
      [5'd1:5'd4]:    w_kind = BLK_DIRT;
      [5'd5:5'd8]:    w_kind = BLK_TUNNEL;
      [5'd9:5'd12]:   w_kind = BLK_ANT;
      [5'd13:5'd16]:  w_kind = BLK_FOOD;
      [5'd17:5'd20]:  w_kind = BLK_QUEEN;
      [5'd21:5'd24]:  w_kind = BLK_EGG;
      default:        w_kind = BLK_INVALID;
    endcase
  end

  assign o_blk = w_kind;

endmodule

`default_nettype wire

// File: rtl/row_bus_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : row_bus_scheduler
// Purpose  : Walks grid rows, decodes one cell per clock, presents each row bus on valid/ready.
// Revision : 1.0
// ============================================================================
module row_bus_scheduler
  import row_bus_scheduler_pkg::*;
#(
  parameter int ROWS = 10,
  parameter int AW   = 4
) (
  input wire logic clk,
  input wire logic rst,
  row_bus_scheduler_if.master sif
);

  localparam logic [AW-1:0]    C_LAST_ROW  = AW'(ROWS - 1);
  localparam logic [CNT_W-1:0] C_LAST_CELL = CNT_W'(CELLS - 1);

  state_t                          r_state;
  logic [CNT_W-1:0]                r_cellCnt;
  logic [CELLS-1:0][CELL_W-1:0]    r_rowReg;
  logic [CELLS-1:0][BLK_W-1:0]     r_busOut;
  logic [AW-1:0]                   r_rowAddr;
  logic [AW-1:0]                   r_busRow;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_donePend;
  logic                            r_rdEn;
  logic                            r_busValid;

  logic [CELL_W-1:0]               w_cellCode;
  logic [BLK_W-1:0]                w_blk;

  assign w_cellCode = r_rowReg[r_cellCnt];

  dispToBlock u_dispToBlock (
    .i_code (w_cellCode),
    .o_blk  (w_blk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cellCnt  <= '0;
      r_rowReg   <= '0;
      r_busOut   <= '0;
      r_rowAddr  <= '0;
      r_busRow   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_donePend <= 1'b0;
      r_rdEn     <= 1'b0;
      r_busValid <= 1'b0;
    end else begin
      // done trails the final handshake by one cycle
      r_done     <= r_donePend;
      r_donePend <= 1'b0;
      r_rdEn     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // start is refused while the previous frame's done is still in flight
          if (sif.start && !r_donePend && !r_done) begin
            r_state   <= ST_FETCH;
            r_rowAddr <= '0;
            r_busy    <= 1'b1;
            r_rdEn    <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_rowReg  <= sif.rd_data;
          r_cellCnt <= '0;
          r_state   <= ST_CONV;
        end
        ST_CONV: begin
          r_busOut[r_cellCnt] <= w_blk;
          if (r_cellCnt == C_LAST_CELL) begin
            r_cellCnt  <= '0;
            r_state    <= ST_HOLD;
            r_busValid <= 1'b1;
            r_busRow   <= r_rowAddr;
          end else begin
            r_cellCnt <= r_cellCnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (sif.bus_ready) begin
            r_busValid <= 1'b0;
            if (r_rowAddr == C_LAST_ROW) begin
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
              r_donePend <= 1'b1;
            end else begin
              r_rowAddr <= r_rowAddr + AW'(1);
              r_state   <= ST_FETCH;
              r_rdEn    <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sif.busy      = r_busy;
  assign sif.done      = r_done;
  assign sif.rd_en     = r_rdEn;
  assign sif.row_addr  = r_rowAddr;
  assign sif.bus_out   = r_busOut;
  assign sif.bus_valid = r_busValid;
  assign sif.bus_row   = r_busRow;

endmodule

`default_nettype wire

// File: tb/tb_row_bus_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_row_bus_scheduler
// Purpose  : Randomized self-checking bench for row_bus_scheduler against a code-table model.
// Revision : 1.0
// ============================================================================
module tb_row_bus_scheduler;
  import row_bus_scheduler_pkg::*;

  localparam int ROWS = 10;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  row_bus_scheduler_if #(.AW(AW)) sif  ();
  row_bus_scheduler_if #(.AW(AW)) sif1 ();

  row_bus_scheduler #(.ROWS(ROWS), .AW(AW)) dut  (.clk(clk), .rst(rst), .sif(sif.master));
  row_bus_scheduler #(.ROWS(1),    .AW(AW)) dut1 (.clk(clk), .rst(rst), .sif(sif1.master));

  logic [ROW_W-1:0] grid [ROWS];

  // Frame observations and knobs
  int               hsRow[$];
  logic [BUS_W-1:0] hsBus[$];
  int firstValid, doneCycle, doneCount, fetchOk, stallCycles, stallBad, busyAfter;
  int readyMode, stallRow, stallLen;
  bit startInj, startAtDone;

  // Codes come in groups of four per block kind; 25..31 are invalid
  function automatic logic [BLK_W-1:0] refBlk(input int code);
    int b;
    if (code == 0) return '0;
    b = (code + 3) / 4;
    if (b > 7) b = 7;
    return BLK_W'(b);
  endfunction

  function automatic logic [BUS_W-1:0] refBus(input logic [ROW_W-1:0] row);
    logic [BUS_W-1:0] r;
    r = '0;
    for (int k = 0; k < CELLS; k++) r[BLK_W*k +: BLK_W] = refBlk(int'(row[CELL_W*k +: CELL_W]));
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] rndRow();
    return ROW_W'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Grid storage: data valid only in the cycle after rd_en, random junk otherwise
  initial begin : rdDriver
    logic          wasRd;
    logic [AW-1:0] addr;
    wasRd = 1'b0;
    addr  = '0;
    sif.rd_data = '0;
    forever begin
      @(negedge clk);
      if (wasRd) sif.rd_data = grid[addr];
      else       sif.rd_data = rndRow();
      wasRd = sif.rd_en;
      addr  = sif.row_addr;
    end
  end

  task automatic runFrame();
    int cyc, stallLeft;
    bit stalling, expectFetch;
    logic [AW-1:0]    fetchRow;
    logic [BUS_W-1:0] holdBus;
    hsRow.delete(); hsBus.delete();
    firstValid = -1; doneCycle = -1; doneCount = 0; fetchOk = 0;
    stallCycles = 0; stallBad = 0; busyAfter = 0;
    stalling = 0; expectFetch = 0; fetchRow = '0; holdBus = '0;
    stallLeft = stallLen;
    @(negedge clk) sif.start = 1'b1;
    @(negedge clk) sif.start = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      if (expectFetch) begin
        if (sif.rd_en === 1'b1 && sif.row_addr === fetchRow) fetchOk++;
        expectFetch = 0;
      end
      if (sif.bus_valid === 1'b1 && firstValid < 0) firstValid = cyc;
      sif.start = 1'b0;
      if (startInj && (cyc == 20 || cyc == 47)) sif.start = 1'b1;
      if (sif.done === 1'b1) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cyc;
        if (startAtDone) sif.start = 1'b1;
      end
      if (doneCycle >= 0 && sif.busy !== 1'b0) busyAfter++;
      if (stalling) begin
        stallCycles++;
        if (sif.bus_valid !== 1'b1 || sif.bus_row !== AW'(stallRow) || sif.bus_out !== holdBus) stallBad++;
      end else if (stallRow >= 0 && sif.bus_valid === 1'b1 && sif.bus_row === AW'(stallRow) && stallLeft > 0) begin
        stalling = 1;
        holdBus  = sif.bus_out;
      end
      if (stalling) begin
        if (stallLeft > 0) begin sif.bus_ready = 1'b0; stallLeft--; end
        else begin stalling = 0; sif.bus_ready = 1'b1; end
      end else begin
        sif.bus_ready = (readyMode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      if (sif.bus_valid === 1'b1 && sif.bus_ready === 1'b1) begin
        hsRow.push_back(int'(sif.bus_row));
        hsBus.push_back(sif.bus_out);
        if (sif.bus_row !== AW'(ROWS - 1)) begin
          expectFetch = 1;
          fetchRow    = sif.bus_row + AW'(1);
        end
      end
      if (doneCycle >= 0 && cyc >= doneCycle + 4) break;
      @(negedge clk);
      cyc++;
    end
    sif.start     = 1'b0;
    sif.bus_ready = 1'b1;
  endtask

  task automatic setKnobs(input int rm, input int sr, input int sl, input bit si, input bit sd);
    readyMode = rm; stallRow = sr; stallLen = sl; startInj = si; startAtDone = sd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    testsRun++;
    if ({sif.busy, sif.done, sif.rd_en, sif.bus_valid} !== 4'b0) begin
      testsFailed++;
      $display("FAIL reset_flags: busy/done/rd_en/valid = %b, want 0000",
               {sif.busy, sif.done, sif.rd_en, sif.bus_valid});
    end
    testsRun++;
    if ({sif.row_addr, sif.bus_row, sif.bus_out} !== '0) begin
      testsFailed++;
      $display("FAIL reset_data: row_addr=%0d bus_row=%0d bus_out=%h, want all 0",
               sif.row_addr, sif.bus_row, sif.bus_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_timing();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < CELLS; k++) grid[r][CELL_W*k +: CELL_W] = CELL_W'(r);
    setKnobs(0, -1, 0, 0, 0);
    runFrame();
    testsRun++;
    if (hsRow.size() != ROWS) begin
      testsFailed++; $display("FAIL frame_hs_count: got %0d want %0d", hsRow.size(), ROWS);
    end
    for (int i = 0; i < ROWS && i < hsRow.size(); i++) begin
      testsRun++;
      if (hsRow[i] != i || hsBus[i] !== refBus(grid[i])) begin
        testsFailed++;
        $display("FAIL frame_row%0d: row=%0d bus=%h want row=%0d bus=%h", i, hsRow[i], hsBus[i], i, refBus(grid[i]));
      end
    end
    testsRun++;
    if (firstValid != 15) begin testsFailed++; $display("FAIL first_valid: got %0d want 15", firstValid); end
    testsRun++;
    if (doneCycle != ROWS*16+1 || doneCount != 1) begin
      testsFailed++; $display("FAIL done_timing: cycle %0d count %0d want %0d/1", doneCycle, doneCount, ROWS*16+1);
    end
    testsRun++;
    if (busyAfter != 0 || fetchOk != ROWS-1) begin
      testsFailed++; $display("FAIL busy_fetch: busyAfter %0d fetchOk %0d want 0/%0d", busyAfter, fetchOk, ROWS-1);
    end
  endtask

  task automatic test_distinct_cells();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < CELLS; k++) grid[r][CELL_W*k +: CELL_W] = CELL_W'((r*CELLS + k) % 32);
    setKnobs(0, -1, 0, 0, 0);
    runFrame();
    testsRun++;
    if (hsRow.size() != ROWS) begin
      testsFailed++; $display("FAIL distinct_hs_count: got %0d want %0d", hsRow.size(), ROWS);
    end
    for (int i = 0; i < ROWS && i < hsRow.size(); i++) begin
      testsRun++;
      if (hsRow[i] != i || hsBus[i] !== refBus(grid[i])) begin
        testsFailed++;
        $display("FAIL distinct_row%0d: row=%0d bus=%h want row=%0d bus=%h", i, hsRow[i], hsBus[i], i, refBus(grid[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < ROWS; r++) grid[r] = rndRow();
    setKnobs(0, 3, 20, 0, 0);
    runFrame();
    testsRun++;
    if (stallCycles != 20 || stallBad != 0) begin
      testsFailed++; $display("FAIL stall_hold: cycles %0d unstable %0d want 20/0", stallCycles, stallBad);
    end
    testsRun++;
    if (hsRow.size() != ROWS || fetchOk != ROWS-1 || doneCycle != ROWS*16+21) begin
      testsFailed++;
      $display("FAIL stall_flow: hs %0d fetchOk %0d done@%0d want %0d/%0d/%0d",
               hsRow.size(), fetchOk, doneCycle, ROWS, ROWS-1, ROWS*16+21);
    end
    for (int i = 0; i < ROWS && i < hsRow.size(); i++) begin
      testsRun++;
      if (hsRow[i] != i || hsBus[i] !== refBus(grid[i])) begin
        testsFailed++;
        $display("FAIL stall_row%0d: row=%0d bus=%h want row=%0d bus=%h", i, hsRow[i], hsBus[i], i, refBus(grid[i]));
      end
    end
  endtask

  task automatic test_start_ignored();
    for (int r = 0; r < ROWS; r++) grid[r] = rndRow();
    setKnobs(0, -1, 0, 1, 0);
    runFrame();
    testsRun++;
    if (hsRow.size() != ROWS || doneCount != 1 || doneCycle != ROWS*16+1) begin
      testsFailed++;
      $display("FAIL start_ignored: hs %0d done %0d@%0d want %0d/1@%0d", hsRow.size(), doneCount, doneCycle, ROWS, ROWS*16+1);
    end
    for (int i = 0; i < ROWS && i < hsRow.size(); i++) begin
      testsRun++;
      if (hsRow[i] != i) begin
        testsFailed++; $display("FAIL start_ignored_order%0d: row %0d want %0d", i, hsRow[i], i);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < ROWS; r++) grid[r] = rndRow();
      setKnobs(1, -1, 0, 0, 1);
      runFrame();
      testsRun++;
      if (hsRow.size() != ROWS || doneCount != 1 || busyAfter != 0) begin
        testsFailed++;
        $display("FAIL random%0d_flow: hs %0d done %0d busyAfter %0d want %0d/1/0", f, hsRow.size(), doneCount, busyAfter, ROWS);
      end
      for (int i = 0; i < ROWS && i < hsRow.size(); i++) begin
        testsRun++;
        if (hsRow[i] != i || hsBus[i] !== refBus(grid[i])) begin
          testsFailed++;
          $display("FAIL random%0d_row%0d: row=%0d bus=%h want row=%0d bus=%h", f, i, hsRow[i], hsBus[i], i, refBus(grid[i]));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int extra;
    for (int r = 0; r < ROWS; r++) grid[r] = rndRow();
    sif.bus_ready = 1'b1;
    @(negedge clk) sif.start = 1'b1;
    @(negedge clk) sif.start = 1'b0;
    repeat (88) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if ({sif.busy, sif.done, sif.rd_en, sif.bus_valid} !== 4'b0 || {sif.row_addr, sif.bus_row, sif.bus_out} !== '0) begin
      testsFailed++;
      $display("FAIL async_reset: busy=%b valid=%b row_addr=%0d bus_row=%0d bus_out=%h, want all 0",
               sif.busy, sif.bus_valid, sif.row_addr, sif.bus_row, sif.bus_out);
    end
    @(negedge clk) rst = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (sif.done !== 1'b0 || sif.busy !== 1'b0) extra++;
    end
    testsRun++;
    if (extra != 0) begin testsFailed++; $display("FAIL abandoned_frame: %0d busy/done cycles, want 0", extra); end
    setKnobs(0, -1, 0, 0, 0);
    runFrame();
    testsRun++;
    if (hsRow.size() != ROWS || hsRow[0] != 0 || doneCount != 1) begin
      testsFailed++;
      $display("FAIL restart: hs %0d first row %0d done %0d want %0d/0/1", hsRow.size(),
               (hsRow.size() > 0) ? hsRow[0] : -1, doneCount, ROWS);
    end
  endtask

  task automatic test_single_row();
    logic [ROW_W-1:0] one;
    logic [BUS_W-1:0] got;
    int hsCyc, dnCyc;
    one = rndRow();
    sif1.rd_data = one;
    hsCyc = -1; dnCyc = -1; got = '0;
    @(negedge clk) sif1.start = 1'b1;
    @(negedge clk) sif1.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sif1.bus_valid === 1'b1 && hsCyc < 0) begin hsCyc = c; got = sif1.bus_out; end
      if (sif1.done === 1'b1 && dnCyc < 0) dnCyc = c;
      @(negedge clk);
    end
    testsRun++;
    if (hsCyc != 15 || got !== refBus(one) || dnCyc != 17) begin
      testsFailed++;
      $display("FAIL single_row: valid@%0d bus=%h done@%0d want 15 %h 17", hsCyc, got, dnCyc, refBus(one));
    end
  endtask

  initial begin
    rst = 1'b1;
    sif.start = 1'b0; sif.bus_ready = 1'b1;
    sif1.start = 1'b0; sif1.bus_ready = 1'b1; sif1.rd_data = '0;
    setKnobs(0, -1, 0, 0, 0);
    test_reset();
    test_frame_timing();
    test_distinct_cells();
    test_backpressure();
    test_start_ignored();
    test_random_frames();
    test_async_reset();
    test_single_row();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

`default_nettype wire
